instr_fetch: RTL and testbench
==============================

// Module: instr_fetch
// PURPOSE
//  Fetch stage feeding opcode_decode: issues PC-sequential reads to a 1-cycle-latency synchronous
//  instruction memory, buffers returned words with their PCs, and presents them downstream on a
//  valid/ready handshake. Accepts branch/jump redirects from execute, flushing all stale fetches.
// PARAMETERS
//  XLEN        32            address/PC width
//  RESET_PC    32'h00000000  first fetch address after reset (must be 4-byte aligned)
//  FIFO_DEPTH  2             buffered instructions; >=2 required for 1 instr/cycle throughput
// PORTS
//  clk             in   1     clock; all state updates on rising edge
//  rst             in   1     synchronous, active-high reset
//  enable          in   1     permits issuing new fetches
//  imem_rd_en      out  1     read strobe to instruction memory
//  imem_addr       out  XLEN  read address (= fetch_pc)
//  imem_rdata      in   32    read data, valid the cycle after imem_rd_en
//  redirect_valid  in   1     load new PC, flush pipeline
//  redirect_pc     in   XLEN  redirect target
//  instr_valid     out  1     instr_word/instr_pc valid
//  instr_ready     in   1     decoder accepts; transfer when valid & ready
//  instr_word      out  32    instruction (opcode = [6:0], funct3 = [14:12])
//  instr_pc        out  XLEN  PC of instr_word
//  fetch_fault     out  1     misaligned redirect trapped
// BEHAVIOUR
//  Reset: state=IDLE, fetch_pc=RESET_PC, FIFO empty, inflight=0, imem_rd_en=0, instr_valid=0,
//   fetch_fault=0. When instr_valid=0: instr_word=32'h00000013 (NOP), instr_pc=0.
//  FSM: IDLE -> RUN when enable=1. RUN -> FAULT on redirect with redirect_pc[1:0]!=0.
//   FAULT -> RUN on aligned redirect. Any state -> IDLE on rst.
//  Issue (RUN only): imem_rd_en = enable & (count + inflight - pop < FIFO_DEPTH), where
//   pop = instr_valid & instr_ready. On issue: inflight<=1, inflight_pc<=fetch_pc, fetch_pc+=4.
//  Return: cycle after issue, {inflight_pc, imem_rdata} pushed into FIFO; inflight<=0 unless
//   reissued. Never pushes to a full FIFO (guaranteed by issue rule; assert in sim).
//  Output: instr_valid = FIFO non-empty & ~redirect_valid; head registered.
//   Latency: request in cycle t -> instr_valid at t+2. Steady state: 1 instr/cycle with ready=1.
//  Holding: while instr_valid & ~instr_ready, instr_word/instr_pc stable.
//  Redirect (highest priority after rst), aligned target P in cycle t: FIFO cleared, response
//   arriving in t discarded, instr_valid=0 in t (no transfer), imem_rd_en=1 with imem_addr=P in t
//   (if enable), fetch_pc<=P+4. First redirected instr valid at t+2.
//  Misaligned redirect: FIFO cleared, in-flight discarded, no issue, fetch_fault=1 held in FAULT,
//   cleared in the cycle an aligned redirect is taken.
//  enable=0 in RUN: no new issue; in-flight completes, FIFO drains normally.
//  PC arithmetic modulo 2^XLEN: 32'hFFFFFFFC + 4 wraps to 0, no fault.
//  rst mid-operation: all in-flight and buffered data dropped; next fetch from RESET_PC.
// STRUCTURE
//  riscv_pkg: ILEN=32, NOP_INSTR=32'h00000013, opcode constants (LOAD, OP_IMM, BRANCH, JAL,
//   JALR, ...), instr_type encodings shared with opcode_decode.
//  Sub-module fetch_fifo: sync FIFO of {XLEN pc, 32 word}, synchronous flush, count output;
//   flush wins over same-cycle push.
//  Top: 3-state FSM, fetch_pc, inflight flag/pc, issue logic.
// TESTING
//  1 Reset, enable=1, ready=1, mem[i]=i: imem_addr 0,4,8 consecutive cycles; instr_valid from
//    cycle 2, instr_pc 0,4,8 back-to-back, no bubbles.
//  2 Backpressure: ready=0 for 5 cycles mid-stream -> at most FIFO_DEPTH entries buffered, no
//    issue while full, head stable; ready=1 resumes in order, no loss/duplication.
//  3 Redirect to 0x100 while FIFO full and fetch in flight -> instr_valid=0 that cycle,
//    imem_addr=0x100 same cycle, next accepted instr_pc=0x100, stale PCs never appear.
//  4 Redirect to 0x102 -> fetch_fault=1, no imem_rd_en, instr_valid=0; later redirect 0x200 ->
//    fault clears, fetch resumes at 0x200.
//  5 RESET_PC=32'hFFFFFFF8: PCs FFFFFFF8, FFFFFFFC, 00000000 with no fault.
//  6 rst asserted with redirect_valid and in-flight fetch -> all outputs at reset values next
//    cycle; after enable, first instr_pc=RESET_PC.

Source files
------------

// File: rtl/instr_fetch_pkg.sv
// Shared fetch/decode definitions: opcodes, instruction classes, fetch FSM states.
package instr_fetch_pkg;

    localparam int XLEN_DEF = 32;
    localparam int ILEN = 32;
    localparam logic [ILEN-1:0] NOP_INSTR = 32'h0000_0013;

    localparam logic [6:0] OPC_LOAD   = 7'b000_0011;
    localparam logic [6:0] OPC_OP_IMM = 7'b001_0011;
    localparam logic [6:0] OPC_AUIPC  = 7'b001_0111;
    localparam logic [6:0] OPC_STORE  = 7'b010_0011;
    localparam logic [6:0] OPC_OP     = 7'b011_0011;
    localparam logic [6:0] OPC_LUI    = 7'b011_0111;
    localparam logic [6:0] OPC_BRANCH = 7'b110_0011;
    localparam logic [6:0] OPC_JALR   = 7'b110_0111;
    localparam logic [6:0] OPC_JAL    = 7'b110_1111;

    typedef enum logic [2:0] {
        IT_R,
        IT_I,
        IT_S,
        IT_B,
        IT_U,
        IT_J
    } instr_type_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_FAULT
    } fetch_state_e;

    function automatic logic is_aligned(input logic [1:0] lsb);
        return lsb == 2'b00;
    endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// Fetch-stage bus: instruction-memory read port plus the decode-side handshake.
interface instr_fetch_if #(
    parameter int XLEN = 32
);
    logic            imem_rd_en;
    logic [XLEN-1:0] imem_addr;
    logic [31:0]     imem_rdata;
    logic            instr_valid;
    logic            instr_ready;
    logic [31:0]     instr_word;
    logic [XLEN-1:0] instr_pc;

    modport master (
        output imem_rd_en,
        output imem_addr,
        input  imem_rdata,
        output instr_valid,
        input  instr_ready,
        output instr_word,
        output instr_pc
    );

    modport slave (
        input  imem_rd_en,
        input  imem_addr,
        output imem_rdata,
        input  instr_valid,
        output instr_ready,
        input  instr_word,
        input  instr_pc
    );
endinterface

// File: rtl/instr_fetch_fifo.sv
// Small synchronous FIFO of {pc, word}; flush beats a same-cycle push.
module instr_fetch_fifo #(
    parameter int W     = 64,
    parameter int DEPTH = 2,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          push,
    input  logic [W-1:0]  wdata,
    input  logic          pop,
    output logic [W-1:0]  rdata,
    output logic          empty,
    output logic [CW-1:0] count
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];
    logic [PW-1:0] wr_q, wr_d;
    logic [PW-1:0] rd_q, rd_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          full;
    logic          do_pop;

    function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty  = (cnt_q == '0);
    assign full   = (cnt_q == CW'(DEPTH));
    assign count  = cnt_q;
    assign rdata  = mem_q[rd_q];
    assign do_pop = pop & ~empty;

    always_comb begin
        mem_d = mem_q;
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (flush) begin
            wr_d  = '0;
            rd_d  = '0;
            cnt_d = '0;
        end else begin
            if (push) begin
                mem_d[wr_q] = wdata;
                wr_d        = inc(wr_q);
            end
            if (do_pop) begin
                rd_d = inc(rd_q);
            end
            cnt_d = cnt_q + CW'(push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
        mem_q <= mem_d;
    end

    // The issue rule upstream must keep this from ever firing.
    always_ff @(posedge clk) begin
        if (!rst && !flush) begin
            assert (!(push && full && !do_pop));
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: PC-sequential reads from a 1-cycle imem, buffered and handed to decode.
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter int              XLEN       = XLEN_DEF,
    parameter logic [XLEN-1:0] RESET_PC   = '0,
    parameter int              FIFO_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            enable,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            fetch_fault,
    instr_fetch_if.master   bus
);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int OW = CW + 1;
    localparam int W  = XLEN + ILEN;

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic            inflight_q, inflight_d;
    logic [XLEN-1:0] inflight_pc_q, inflight_pc_d;

    logic            redir_ok;
    logic            redir_bad;
    logic            pop;
    logic            push;
    logic            can_run;
    logic            issue;
    logic [XLEN-1:0] addr;
    logic [OW-1:0]   occ;
    logic [W-1:0]    head;
    logic            empty;
    logic [CW-1:0]   count;
    logic            valid;

    assign redir_ok  = redirect_valid & is_aligned(redirect_pc[1:0]);
    assign redir_bad = redirect_valid & ~redir_ok;
    assign valid     = ~empty & ~redirect_valid;
    assign pop       = valid & bus.instr_ready;
    assign push      = inflight_q & ~redirect_valid;
    assign addr      = redir_ok ? redirect_pc : fetch_pc_q;

    // A redirect empties both the FIFO and the in-flight slot this cycle.
    always_comb begin
        occ = '0;
        if (!redirect_valid) begin
            occ = OW'(count) + OW'(inflight_q) - OW'(pop);
        end
    end

    always_comb begin
        can_run = 1'b0;
        unique case (1'b1)
            (state_q == ST_RUN):   can_run = ~redir_bad;
            (state_q == ST_FAULT): can_run = redir_ok;
            default:               can_run = 1'b0;
        endcase
    end

    assign issue = can_run & enable & (occ < OW'(FIFO_DEPTH));

    always_comb begin
        state_d       = state_q;
        fetch_pc_d    = fetch_pc_q;
        inflight_d    = issue;
        inflight_pc_d = inflight_pc_q;
        unique case (state_q)
            ST_IDLE: begin
                if (redir_bad) state_d = ST_FAULT;
                else if (enable) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (redir_bad) state_d = ST_FAULT;
            end
            ST_FAULT: begin
                if (redir_ok) state_d = ST_RUN;
            end
            default: state_d = ST_IDLE;
        endcase
        if (issue) begin
            fetch_pc_d    = addr + XLEN'(4);
            inflight_pc_d = addr;
        end else if (redir_ok) begin
            fetch_pc_d = redirect_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            fetch_pc_q    <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
        end
    end

    instr_fetch_fifo #(
        .W     (W),
        .DEPTH (FIFO_DEPTH),
        .CW    (CW)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (redirect_valid),
        .push  (push),
        .wdata ({inflight_pc_q, bus.imem_rdata}),
        .pop   (pop),
        .rdata (head),
        .empty (empty),
        .count (count)
    );

    assign bus.imem_rd_en  = issue;
    assign bus.imem_addr   = addr;
    assign bus.instr_valid = valid;
    assign bus.instr_word  = valid ? head[ILEN-1:0] : NOP_INSTR;
    assign bus.instr_pc    = valid ? head[W-1:ILEN] : '0;
    assign fetch_fault     = (state_q == ST_FAULT) & ~redir_ok;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed plus random checks of instr_fetch against a queue-based fetch model.
module tb_instr_fetch;

    localparam int DEPTH = 2;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst, enable, rv, fault;
    logic [31:0] rpc;
    logic        rst2, en2, rv2, fault2;
    logic [31:0] rpc2;

    int errors = 0;
    int checks = 0;
    int n = 0;

    instr_fetch_if #(.XLEN(32)) bus0 ();
    instr_fetch_if #(.XLEN(32)) bus1 ();

    instr_fetch #(
        .XLEN(32), .RESET_PC(32'h0), .FIFO_DEPTH(DEPTH)
    ) u_dut (
        .clk(clk), .rst(rst), .enable(enable),
        .redirect_valid(rv), .redirect_pc(rpc),
        .fetch_fault(fault), .bus(bus0)
    );

    instr_fetch #(
        .XLEN(32), .RESET_PC(32'hFFFF_FFF8), .FIFO_DEPTH(DEPTH)
    ) u_dut2 (
        .clk(clk), .rst(rst2), .enable(en2),
        .redirect_valid(rv2), .redirect_pc(rpc2),
        .fetch_fault(fault2), .bus(bus1)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return (a >> 2) ^ 32'h1357_0000;
    endfunction

    always @(posedge clk) begin
        if (bus0.imem_rd_en) bus0.imem_rdata <= memf(bus0.imem_addr);
        if (bus1.imem_rd_en) bus1.imem_rdata <= memf(bus1.imem_addr);
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Model: every fetch issued and not yet consumed, tagged with its issue cycle.
    typedef struct {
        logic [31:0] pc;
        int          cyc;
    } pend_t;

    pend_t       pend[$];
    int          mode = 0;
    logic [31:0] nxt = 32'h0;

    task automatic model_step();
        logic al, mis, ev, er, run_ok;
        logic [31:0] a;
        if (rst) begin
            pend.delete();
            mode = 0;
            nxt  = 32'h0;
            n++;
            return;
        end
        al  = rv && (rpc[1:0] == 2'b00);
        mis = rv && !al;
        if (rv) pend.delete();
        ev = !rv && pend.size() > 0 && (pend[0].cyc + 2 <= n);
        chk("m_valid", {31'b0, bus0.instr_valid}, {31'b0, ev});
        if (ev) begin
            chk("m_pc", bus0.instr_pc, pend[0].pc);
            chk("m_word", bus0.instr_word, memf(pend[0].pc));
            if (bus0.instr_ready) void'(pend.pop_front());
        end else begin
            chk("m_nop", bus0.instr_word, NOP);
            chk("m_pc0", bus0.instr_pc, 32'h0);
        end
        run_ok = (mode == 1 && !mis) || (mode == 2 && al);
        er = enable && run_ok && (pend.size() < DEPTH);
        a  = al ? rpc : nxt;
        chk("m_rd_en", {31'b0, bus0.imem_rd_en}, {31'b0, er});
        if (er) chk("m_addr", bus0.imem_addr, a);
        chk("m_fault", {31'b0, fault}, {31'b0, (mode == 2) && !al});
        if (er) begin
            pend.push_back('{pc: a, cyc: n});
            nxt = a + 32'd4;
        end else if (al) begin
            nxt = rpc;
        end
        if (mis) mode = 2;
        else if (mode == 2 && al) mode = 1;
        else if (mode == 0 && enable) mode = 1;
        n++;
    endtask

    task automatic cyc();
        #1;
        model_step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] addrs[$];
        logic [31:0] pcs[$];
        logic [31:0] hold[5];
        logic [31:0] q2[$];
        int first_rd, first_v, bubbles, nf, waited;
        logic got;

        rst = 1; enable = 0; rv = 0; rpc = 0;
        bus0.instr_ready = 1;
        rst2 = 1; en2 = 0; rv2 = 0; rpc2 = 0;
        bus1.instr_ready = 1;
        @(posedge clk);
        #1;
        cyc();
        cyc();

        // Reset values
        rst = 0;
        #1;
        chk("rst_rd_en", {31'b0, bus0.imem_rd_en}, 32'h0);
        chk("rst_valid", {31'b0, bus0.instr_valid}, 32'h0);
        chk("rst_word", bus0.instr_word, NOP);
        chk("rst_pc", bus0.instr_pc, 32'h0);
        chk("rst_fault", {31'b0, fault}, 32'h0);

        // Sequential fetch, no bubbles
        enable = 1;
        first_rd = -1; first_v = -1; bubbles = 0;
        for (int i = 0; i < 8; i++) begin
            #1;
            if (bus0.imem_rd_en) begin
                addrs.push_back(bus0.imem_addr);
                if (first_rd < 0) first_rd = i;
            end
            if (bus0.instr_valid) begin
                pcs.push_back(bus0.instr_pc);
                if (first_v < 0) first_v = i;
            end else if (first_v >= 0) begin
                bubbles++;
            end
            cyc();
        end
        chk("seq_addr0", addrs[0], 32'h0);
        chk("seq_addr1", addrs[1], 32'h4);
        chk("seq_addr2", addrs[2], 32'h8);
        chk("seq_latency", first_v, first_rd + 2);
        chk("seq_pc0", pcs[0], 32'h0);
        chk("seq_pc1", pcs[1], 32'h4);
        chk("seq_pc2", pcs[2], 32'h8);
        chk("seq_bubbles", bubbles, 0);

        // Backpressure: head holds, no issue while full
        bus0.instr_ready = 0;
        for (int i = 0; i < 5; i++) begin
            #1;
            hold[i] = bus0.instr_pc;
            if (i == 4) begin
                chk("bp_rd_en", {31'b0, bus0.imem_rd_en}, 32'h0);
                chk("bp_valid", {31'b0, bus0.instr_valid}, 32'h1);
            end
            cyc();
        end
        chk("bp_hold", hold[4], hold[0]);
        bus0.instr_ready = 1;
        for (int i = 0; i < 6; i++) cyc();

        // Redirect while FIFO full
        bus0.instr_ready = 0;
        for (int i = 0; i < 3; i++) cyc();
        rv = 1; rpc = 32'h100; bus0.instr_ready = 1;
        #1;
        chk("rd_valid", {31'b0, bus0.instr_valid}, 32'h0);
        chk("rd_rd_en", {31'b0, bus0.imem_rd_en}, 32'h1);
        chk("rd_addr", bus0.imem_addr, 32'h100);
        cyc();
        rv = 0;
        cyc();
        #1;
        chk("rd_t2_valid", {31'b0, bus0.instr_valid}, 32'h1);
        chk("rd_t2_pc", bus0.instr_pc, 32'h100);
        for (int i = 0; i < 5; i++) cyc();

        // Misaligned redirect traps, aligned one recovers
        rv = 1; rpc = 32'h102;
        #1;
        chk("mis_rd_en", {31'b0, bus0.imem_rd_en}, 32'h0);
        chk("mis_valid", {31'b0, bus0.instr_valid}, 32'h0);
        cyc();
        rv = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("flt_fault", {31'b0, fault}, 32'h1);
            chk("flt_rd_en", {31'b0, bus0.imem_rd_en}, 32'h0);
            cyc();
        end
        rv = 1; rpc = 32'h200;
        #1;
        chk("rec_fault", {31'b0, fault}, 32'h0);
        chk("rec_addr", bus0.imem_addr, 32'h200);
        cyc();
        rv = 0;
        cyc();
        #1;
        chk("rec_pc", bus0.instr_pc, 32'h200);
        cyc();

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            bus0.instr_ready = ($urandom_range(0, 9) < 7);
            enable = ($urandom_range(0, 9) != 0);
            rv = 0;
            if ($urandom_range(0, 19) == 0) begin
                rv = 1;
                rpc = $urandom & 32'hFFFF_FFFC;
            end else if ($urandom_range(0, 59) == 0) begin
                rv = 1;
                rpc = $urandom | 32'h1;
            end
            cyc();
        end
        rv = 0;

        // PC wraparound on the second instance
        rst = 1;
        enable = 0;
        cyc();
        rst2 = 0; en2 = 1;
        nf = 0;
        for (int i = 0; i < 10; i++) begin
            cyc();
            if (bus1.instr_valid) q2.push_back(bus1.instr_pc);
            if (fault2) nf++;
        end
        chk("wrap_count", {31'b0, q2.size() >= 3}, 32'h1);
        if (q2.size() >= 3) begin
            chk("wrap_pc0", q2[0], 32'hFFFF_FFF8);
            chk("wrap_pc1", q2[1], 32'hFFFF_FFFC);
            chk("wrap_pc2", q2[2], 32'h0000_0000);
        end
        chk("wrap_fault", nf, 0);

        // Reset with a redirect and an in-flight fetch
        rst = 0; enable = 1; bus0.instr_ready = 1;
        for (int i = 0; i < 4; i++) cyc();
        rst = 1; rv = 1; rpc = 32'h300;
        cyc();
        rst = 0; rv = 0; enable = 0;
        #1;
        chk("r6_rd_en", {31'b0, bus0.imem_rd_en}, 32'h0);
        chk("r6_valid", {31'b0, bus0.instr_valid}, 32'h0);
        chk("r6_word", bus0.instr_word, NOP);
        chk("r6_pc", bus0.instr_pc, 32'h0);
        chk("r6_fault", {31'b0, fault}, 32'h0);
        cyc();
        enable = 1;
        got = 0;
        waited = 0;
        while (!got && waited < 10) begin
            #1;
            if (bus0.instr_valid) begin
                got = 1;
                chk("r6_first_pc", bus0.instr_pc, 32'h0);
            end
            cyc();
            waited++;
        end
        chk("r6_timeout", {31'b0, got}, 32'h1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
